// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// onehot() works at the widest legal select width; callers size-cast the result.
package decoder_pkg;

  localparam int N_MAX    = 6;
  localparam int OUTS_MAX = 2 ** N_MAX;

  typedef enum logic [1:0] {
    DIRECT = 2'b00,
    SCAN   = 2'b01,
    PULSE  = 2'b10,
    RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DIRECT     = 3'd1,
    ST_PULSE_WAIT = 3'd2,
    ST_PULSE_FIRE = 3'd3,
    ST_SCAN       = 3'd4
  } state_e;

  function automatic logic [OUTS_MAX-1:0] onehot(input logic [N_MAX-1:0] idx);
    return OUTS_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/decoder_seq_if.sv
// Select handshake and decoded-output bundle for decoder_seq.
interface decoder_seq_if #(parameter int N = 3);
  localparam int OUTS = 2 ** N;

  logic            en;
  logic [1:0]      mode;
  logic [N-1:0]    sel;
  logic            sel_valid;
  logic            sel_ready;
  logic [OUTS-1:0] y;
  logic            y_valid;
  logic            wrap;

  modport master (
    output en, mode, sel, sel_valid,
    input  sel_ready, y, y_valid, wrap
  );

  modport slave (
    input  en, mode, sel, sel_valid,
    output sel_ready, y, y_valid, wrap
  );
endinterface

// File: rtl/decoder_scan_ctr.sv
// Dwell counter and walking index for the scan mode of decoder_seq.
// step/wrap_p are combinational and announce the advance taken on the next edge.
module decoder_scan_ctr #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         run,
  output logic [N-1:0] index,
  output logic         step,
  output logic         wrap_p
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign step   = run & (cnt == CNT_LAST);
  assign wrap_p = step & (index == {N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      index <= '0;
    end else if (clear) begin
      cnt   <= '0;
      index <= '0;
    end else if (run) begin
      if (step) begin
        cnt   <= '0;
        index <= index + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with direct, pulse and scan modes.
//   state      | meaning
//   IDLE       | outputs cleared, waiting for en and a legal mode
//   DIRECT_S   | y follows last accepted sel, held
//   PULSE_WAIT | ready for a sel to strobe
//   PULSE_FIRE | strobe cycle, y clears next edge
//   SCAN_S     | autonomous walking one-hot, sel ignored
module decoder_seq #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  decoder_seq_if.slave bus
);
  import decoder_pkg::*;

  localparam int OUTS = 2 ** N;

  localparam logic [2:0] IDLE       = 3'(ST_IDLE);
  localparam logic [2:0] DIRECT_S   = 3'(ST_DIRECT);
  localparam logic [2:0] PULSE_WAIT = 3'(ST_PULSE_WAIT);
  localparam logic [2:0] PULSE_FIRE = 3'(ST_PULSE_FIRE);
  localparam logic [2:0] SCAN_S     = 3'(ST_SCAN);

  logic [2:0]      state, state_nx;
  logic [OUTS-1:0] y_q, y_nx;
  logic            y_valid_q, wrap_q, wrap_nx;
  logic            mode_match, stay, accept;
  logic            scan_clear, scan_run, scan_step, scan_wrap;
  logic [N-1:0]    scan_index, index_nx;

  always_comb begin
    mode_match = 1'b0;
    case (state)
      DIRECT_S:               mode_match = (bus.mode == DIRECT);
      PULSE_WAIT, PULSE_FIRE: mode_match = (bus.mode == PULSE);
      SCAN_S:                 mode_match = (bus.mode == SCAN);
      default:                mode_match = 1'b0;
    endcase
  end

  assign stay          = bus.en & mode_match;
  // Ready reflects this cycle's mode, so a same-cycle mode change blocks the accept.
  assign bus.sel_ready = bus.en & (((state == DIRECT_S) & (bus.mode == DIRECT)) |
                                   ((state == PULSE_WAIT) & (bus.mode == PULSE)));
  assign accept        = bus.sel_valid & bus.sel_ready;

  assign scan_clear = (state != SCAN_S);
  assign scan_run   = (state == SCAN_S) & stay;
  assign index_nx   = scan_index + 1'b1;

  decoder_scan_ctr #(.N(N), .DWELL(DWELL)) u_scan_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (scan_clear),
    .run    (scan_run),
    .index  (scan_index),
    .step   (scan_step),
    .wrap_p (scan_wrap)
  );

  always_comb begin
    state_nx = state;
    y_nx     = y_q;
    wrap_nx  = 1'b0;
    if (state == IDLE) begin
      y_nx = '0;
      if (bus.en) begin
        case (bus.mode)
          DIRECT: state_nx = DIRECT_S;
          PULSE:  state_nx = PULSE_WAIT;
          SCAN: begin
            state_nx = SCAN_S;
            y_nx     = OUTS'(1);
          end
          default: state_nx = IDLE;
        endcase
      end
    end else if (!stay) begin
      state_nx = IDLE;
      y_nx     = '0;
    end else begin
      case (state)
        DIRECT_S: if (accept) y_nx = OUTS'(onehot(N_MAX'(bus.sel)));
        PULSE_WAIT: if (accept) begin
          y_nx     = OUTS'(onehot(N_MAX'(bus.sel)));
          state_nx = PULSE_FIRE;
        end
        PULSE_FIRE: begin
          y_nx     = '0;
          state_nx = PULSE_WAIT;
        end
        SCAN_S: if (scan_step) begin
          y_nx    = OUTS'(onehot(N_MAX'(index_nx)));
          wrap_nx = scan_wrap;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      y_q       <= y_nx;
      y_valid_q <= |y_nx;
      wrap_q    <= wrap_nx;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: main instance N=3/DWELL=4, a second N=2/DWELL=1
// instance shares the controls to cover the single-cycle dwell case during scan.
module tb_decoder_seq;

  logic clk;
  logic rst_n;

  decoder_seq_if #(.N(3)) bus ();
  decoder_seq_if #(.N(2)) bus1 ();

  decoder_seq #(.N(3), .DWELL(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  decoder_seq #(.N(2), .DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus1.en        = bus.en;
  assign bus1.mode      = bus.mode;
  assign bus1.sel       = bus.sel[1:0];
  assign bus1.sel_valid = bus.sel_valid;

  typedef struct {
    logic [7:0] y;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check ready, then queue the outputs expected after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [2:0] s, input logic v,
                      input logic rdy, input logic [7:0] ey, input logic ew);
    bus.en        = e;
    bus.mode      = m;
    bus.sel       = s;
    bus.sel_valid = v;
    #1;
    chk("sel_ready", 64'(bus.sel_ready), 64'(rdy));
    @(posedge clk);
    #1;
    q.push_back('{ey, ew});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y", 64'(bus.y), 64'(e.y));
        chk("y_valid", 64'(bus.y_valid), 64'(|e.y));
        chk("wrap", 64'(bus.wrap), 64'(e.w));
      end else if (bus.y_valid) begin
        chk("unexpected_y_valid", 64'(bus.y_valid), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] ey;
    logic [3:0] ey1;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.sel       = 3'd0;
    bus.sel_valid = 1'b0;
    #2;
    chk("rst_y", 64'(bus.y), 64'(0));
    chk("rst_y_valid", 64'(bus.y_valid), 64'(0));
    chk("rst_wrap", 64'(bus.wrap), 64'(0));
    chk("rst_sel_ready", 64'(bus.sel_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // direct: IDLE cycle not ready, then accept and hold
    step(1, 2'b00, 3'd5, 1, 0, 8'h00, 0);
    step(1, 2'b00, 3'd5, 1, 1, 8'h20, 0);
    step(1, 2'b00, 3'd5, 0, 1, 8'h20, 0);
    step(1, 2'b00, 3'd2, 0, 1, 8'h20, 0);
    // back-to-back accepts
    step(1, 2'b00, 3'd0, 1, 1, 8'h01, 0);
    step(1, 2'b00, 3'd7, 1, 1, 8'h80, 0);
    step(1, 2'b00, 3'd3, 1, 1, 8'h08, 0);
    step(1, 2'b00, 3'd3, 0, 1, 8'h08, 0);
    // en drop clears on the next edge
    step(0, 2'b00, 3'd3, 1, 0, 8'h00, 0);

    // pulse with sel_valid held
    step(1, 2'b10, 3'd2, 1, 0, 8'h00, 0);
    step(1, 2'b10, 3'd2, 1, 1, 8'h04, 0);
    step(1, 2'b10, 3'd2, 1, 0, 8'h00, 0);
    step(1, 2'b10, 3'd2, 1, 1, 8'h04, 0);
    step(1, 2'b10, 3'd2, 1, 0, 8'h00, 0);
    step(1, 2'b10, 3'd2, 1, 1, 8'h04, 0);

    // async reset while in PULSE_FIRE
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", 64'(bus.y), 64'(0));
    chk("async_rst_y_valid", 64'(bus.y_valid), 64'(0));
    chk("async_rst_wrap", 64'(bus.wrap), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // re-entry through IDLE
    step(1, 2'b10, 3'd1, 1, 0, 8'h00, 0);
    step(1, 2'b10, 3'd1, 1, 1, 8'h02, 0);
    step(1, 2'b10, 3'd1, 0, 0, 8'h00, 0);

    // pulse -> scan: one edge to IDLE, one to SCAN_S with bit 0
    step(1, 2'b01, 3'd0, 0, 0, 8'h00, 0);
    step(1, 2'b01, 3'd0, 0, 0, 8'h01, 0);
    chk("dw1_entry_y", 64'(bus1.y), 64'(4'h1));
    chk("dw1_entry_wrap", 64'(bus1.wrap), 64'(0));
    for (int c = 1; c <= 35; c++) begin
      ey = 8'h01 << ((c / 4) % 8);
      step(1, 2'b01, 3'd0, 0, 0, ey, (c == 32));
      ey1 = 4'h1 << (c % 4);
      chk("dw1_y", 64'(bus1.y), 64'(ey1));
      chk("dw1_wrap", 64'(bus1.wrap), 64'((c % 4) == 0));
    end

    // scan -> direct with sel_valid in the switch cycle: no accept
    step(1, 2'b00, 3'd6, 1, 0, 8'h00, 0);
    step(1, 2'b00, 3'd6, 1, 0, 8'h00, 0);
    step(1, 2'b00, 3'd6, 1, 1, 8'h40, 0);
    step(0, 2'b00, 3'd6, 0, 0, 8'h00, 0);
    step(0, 2'b00, 3'd6, 0, 0, 8'h00, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised N-to-2^N one-hot decoder with a valid/ready select handshake and three operating modes: direct (latched), pulse (one-cycle strobe) and scan (autonomous walking one-hot with wrap flag). It replaces the purely combinational 3-to-8 decoders wherever a glitch-free registered select, a strobe or a sequenced enable (display digit scan, bank walk) is needed.

## Interface
- N, default 3: select width; OUTS = 2**N outputs. Legal range 1..6.
- DWELL, default 4: cycles each output stays active in scan mode. Must be ≥1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 forces IDLE.
- mode  in  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved (behaves as IDLE).
- sel  in  N  output index to activate.
- sel_valid  in  1  sel is valid.
- sel_ready  out  1  block accepts sel this cycle.
- y  out  OUTS  registered one-hot (or all-zero) output.
- y_valid  out  1  registered; equals |y.
- wrap  out  1  registered one-cycle pulse when the scan returns to bit 0.

## Operation
- States: IDLE, DIRECT_S, PULSE_WAIT, PULSE_FIRE, SCAN_S.
- Reset: state IDLE; y=0, y_valid=0, wrap=0, sel_ready=0, dwell counter and scan index 0.
- Accept = sel_valid & sel_ready. sel_ready = en & ((state==DIRECT_S & mode==00) | (state==PULSE_WAIT & mode==10)); it is 0 in every other state, including IDLE.
- IDLE: y=0. If en: mode 00→DIRECT_S, 01→SCAN_S (y←bit 0, counter 0), 10→PULSE_WAIT, 11→stay IDLE.
- Any non-IDLE state: en=0 or mode no longer matches the state → IDLE with y←0 on the same edge. A mode change therefore takes two edges (→IDLE→new state).
- DIRECT_S: on accept, y←1<<sel. y holds until the next accept or exit. Back-to-back accepts are allowed every cycle.
- PULSE_WAIT: on accept, y←1<<sel and go to PULSE_FIRE.
- PULSE_FIRE: y←0 and go to PULSE_WAIT. Maximum throughput is one accept per two cycles.
- SCAN_S: sel ignored. The dwell counter counts 0..DWELL-1. At DWELL-1 the counter resets and the index increments modulo OUTS, y←1<<index. On OUTS-1→0, wrap←1 for that one cycle only. There is no wrap on initial entry.
- Out-of-range is impossible (sel is N bits). sel is sampled only on accept.

## Timing
- Latency 1 cycle: accept at edge k → y valid after edge k. y_valid tracks y on the same edge.
- Pulse width is exactly 1 cycle.
- Scan period is OUTS*DWELL cycles. Bit 0 becomes active after the IDLE→SCAN_S edge.
- If accept and a mode change happen in the same cycle, the accept is blocked because sel_ready already reflects the new mode. No output update occurs.
- If rst_n falls mid-scan or mid-pulse, all outputs clear immediately (asynchronous). After release, the block starts in IDLE and the first mode state is entered on the first edge with en=1.
- DWELL=1: the index advances every cycle, and wrap is coincident with y=bit 0.

## Structure
- Package decoder_pkg:
  - mode_e: DIRECT=2'b00, SCAN=2'b01, PULSE=2'b10, RSVD=2'b11.
  - state_e.
  - function onehot(N-bit) returning the OUTS-bit vector.
- Sub-module decoder_scan_ctr (params N, DWELL): dwell counter of width $clog2(DWELL)+1 plus scan index.
  - Inputs: clk, rst_n, clear, run.
  - Outputs: index, step, wrap_p.
- Top level: FSM, sel_ready logic, y/y_valid/wrap registers.

## Test plan
- Reset then en=1, mode=00, sel=5 with valid → sel_ready=0 in the IDLE cycle. On the next cycle it is accepted, and y=8'b0010_0000, y_valid=1 one edge later and holding.
- DIRECT back-to-back sel=0,7,3 on consecutive cycles → y=01h, 80h, 08h on consecutive cycles.
- PULSE, sel_valid held high with sel=2 → y=04h every other cycle and 0 between. sel_ready alternates 1/0.
- SCAN with DWELL=4 → y=01h for 4 cycles, then 02h … 80h. wrap=1 only in the first cycle y returns to 01h, i.e. 32 cycles after entry.
- Mid-scan mode 01→00 with sel_valid=1 in the same cycle → no accept. y=0 for one cycle, then DIRECT_S, and sel_ready=1 the following cycle.
- rst_n low during PULSE_FIRE, and en=0 mid-DIRECT → y, y_valid and wrap clear immediately (reset) or on the next edge (en). The block re-enters via IDLE.
